// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: frame decode, 3-byte packet assembly, clamped cursor tracking.
// Optional watchdog on stalled frames/packets enabled by defining PS2_MOUSE_WATCHDOG_EN.
module ps2_mouse_tracker #(
  parameter int unsigned POS_W          = 10,
  parameter int unsigned X_MAX          = 159,
  parameter int unsigned Y_MAX          = 119,
  parameter int unsigned X_INIT         = 80,
  parameter int unsigned Y_INIT         = 60,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned Y_INVERT       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [POS_W-1:0] mouse_x,
  output logic [POS_W-1:0] mouse_y,
  output logic             left_button,
  output logic             right_button,
  output logic             middle_button,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
  output logic             packet_valid,
  output logic             frame_error
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("ps2_mouse_tracker: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES > 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
  typedef logic signed [POS_W+1:0] pos_t;

  localparam pos_t X_MAX_S = pos_t'(X_MAX);
  localparam pos_t Y_MAX_S = pos_t'(Y_MAX);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic       clk_prev, sample, bit_in, timeout;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       parity_bit;
  logic       start_en, shift_en, parity_en, byte_ok, byte_bad;
  logic [1:0] idx;
  logic [2:0] stat_btn;
  logic       stat_xs, stat_ys, stat_xo, stat_yo;
  logic [7:0] x_byte;
  logic signed [8:0] dx_new, dy_new;
  pos_t nx, ny;
  logic [POS_W-1:0] x_clamped, y_clamped;

  // Sync flops idle high so reset never looks like a falling PS/2 clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sample = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

`ifdef PS2_MOUSE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state != S_IDLE) || (idx != 2'd0);
  assign timeout   = !sample && wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || sample || timeout || !wd_active) wd_cnt <= '0;
    else                                          wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = S_IDLE;
    end else if (sample) begin
      case (state)
        S_IDLE:   if (!bit_in) state_next = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_en  = sample && (state == S_IDLE) && !bit_in;
    shift_en  = sample && (state == S_DATA);
    parity_en = sample && (state == S_PARITY);
    byte_ok   = sample && (state == S_STOP) && bit_in && (^{shift_reg, parity_bit});
    byte_bad  = sample && (state == S_STOP) && !(bit_in && (^{shift_reg, parity_bit}));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (start_en)       bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)       shift_reg <= {bit_in, shift_reg[7:1]};
      if (parity_en)      parity_bit <= bit_in;
    end
  end

  // The Y byte is still in shift_reg when the packet completes, so deltas are built from it directly.
  always_comb begin
    dx_new = stat_xo ? '0 : {stat_xs, x_byte};
    dy_new = stat_yo ? '0 : {stat_ys, shift_reg};
    nx = pos_t'({2'b00, mouse_x}) + pos_t'(dx_new);
    if (Y_INVERT != 0) ny = pos_t'({2'b00, mouse_y}) - pos_t'(dy_new);
    else               ny = pos_t'({2'b00, mouse_y}) + pos_t'(dy_new);
    if (nx < 0)             x_clamped = '0;
    else if (nx > X_MAX_S)  x_clamped = POS_W'(X_MAX);
    else                    x_clamped = nx[POS_W-1:0];
    if (ny < 0)             y_clamped = '0;
    else if (ny > Y_MAX_S)  y_clamped = POS_W'(Y_MAX);
    else                    y_clamped = ny[POS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= 2'd0;
      stat_btn      <= '0;
      {stat_xs, stat_ys, stat_xo, stat_yo} <= '0;
      x_byte        <= '0;
      mouse_x       <= POS_W'(X_INIT);
      mouse_y       <= POS_W'(Y_INIT);
      left_button   <= 1'b0;
      right_button  <= 1'b0;
      middle_button <= 1'b0;
      dx            <= '0;
      dy            <= '0;
      packet_valid  <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
      if (timeout || byte_bad) begin
        idx         <= 2'd0;
        frame_error <= 1'b1;
      end else if (byte_ok) begin
        case (idx)
          2'd0: if (shift_reg[3]) begin
            stat_btn <= shift_reg[2:0];
            stat_xs  <= shift_reg[4];
            stat_ys  <= shift_reg[5];
            stat_xo  <= shift_reg[6];
            stat_yo  <= shift_reg[7];
            idx      <= 2'd1;
          end
          2'd1: begin
            x_byte <= shift_reg;
            idx    <= 2'd2;
          end
          default: begin
            idx           <= 2'd0;
            mouse_x       <= x_clamped;
            mouse_y       <= y_clamped;
            left_button   <= stat_btn[0];
            right_button  <= stat_btn[1];
            middle_button <= stat_btn[2];
            dx            <= dx_new;
            dy            <= dy_new;
            packet_valid  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: expected packets are queued as bytes are driven
// and compared when packet_valid strobes.
module tb_ps2_mouse_tracker;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] mouse_x, mouse_y;
  logic       left_button, right_button, middle_button;
  logic [8:0] dx, dy;
  logic       packet_valid, frame_error;

  ps2_mouse_tracker #(
    .POS_W(10), .X_MAX(159), .Y_MAX(119), .X_INIT(80), .Y_INIT(60),
    .SYNC_STAGES(2), .Y_INVERT(1), .TIMEOUT_CYCLES(50000)
  ) dut (
    .clk(CLOCK_50), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .left_button(left_button), .right_button(right_button), .middle_button(middle_button),
    .dx(dx), .dy(dy), .packet_valid(packet_valid), .frame_error(frame_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int x, y, l, r, m, dxv, dyv;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned stop_fall_cyc = 0;
  int          n_checks = 0, n_pass = 0;
  int          fe_cycles = 0, fe_exp = 0, pv_count = 0, pv_exp = 0, overlap = 0;
  int          mx = 80, my = 60;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  always @(negedge CLOCK_50) begin
    if (frame_error) fe_cycles++;
    if (frame_error && packet_valid) overlap++;
    if (packet_valid) begin
      pv_count++;
      if (sb.size() == 0) begin
        check_eq("unexpected_packet", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("mouse_x", int'(mouse_x), mon_e.x);
        check_eq("mouse_y", int'(mouse_y), mon_e.y);
        check_eq("left", int'(left_button), mon_e.l);
        check_eq("right", int'(right_button), mon_e.r);
        check_eq("middle", int'(middle_button), mon_e.m);
        check_eq("dx", int'($signed(dx)), mon_e.dxv);
        check_eq("dy", int'($signed(dy)), mon_e.dyv);
        check_eq("latency", int'(cyc - stop_fall_cyc), 3);
      end
    end
  end

  task automatic send_bit(input logic b, input bit is_stop);
    @(negedge CLOCK_50);
    ps2_data = b;
    repeat (10) @(negedge CLOCK_50);
    ps2_clk = 1'b0;
    if (is_stop) stop_fall_cyc = cyc;
    repeat (10) @(negedge CLOCK_50);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_parity);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(fr[i], i == 10);
    repeat (20) @(negedge CLOCK_50);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    int   dxv, dyv;
    dxv = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dyv = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clamp(mx + dxv, 159);
    my = clamp(my - dyv, 119);
    e.x = mx; e.y = my; e.l = b0[0]; e.r = b0[1]; e.m = b0[2];
    e.dxv = dxv; e.dyv = dyv;
    sb.push_back(e);
    pv_exp++;
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLOCK_50);
    check_eq("packet_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic send_partial();
    logic [10:0] fr;
    fr = {1'b1, 1'b1, 8'h15, 1'b0};
    for (int i = 0; i < 6; i++) send_bit(fr[i], 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_eq("rst_x", int'(mouse_x), 80);
    check_eq("rst_y", int'(mouse_y), 60);
    check_eq("rst_buttons", int'({middle_button, right_button, left_button}), 0);
    check_eq("rst_dx", int'(dx), 0);
    check_eq("rst_dy", int'(dy), 0);
    check_eq("rst_strobes", int'({packet_valid, frame_error}), 0);

    send_packet(8'h08, 8'h05, 8'h03);
    send_packet(8'h19, 8'h9C, 8'h00);
    send_packet(8'h08, 8'hFF, 8'h00);
    send_packet(8'h18, 8'h9C, 8'h00);
    send_packet(8'h08, 8'h00, 8'h7F);
    send_packet(8'h28, 8'h00, 8'h80);
    send_packet(8'h48, 8'h10, 8'h00);

    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    fe_exp++;
    check_eq("fe_after_parity", fe_cycles, fe_exp);
    send_packet(8'h08, 8'h01, 8'h00);

    send_byte(8'h00, 1'b0);
    send_packet(8'h08, 8'h02, 8'h00);
    check_eq("fe_after_drop", fe_cycles, fe_exp);

    send_partial();
`ifdef PS2_MOUSE_WATCHDOG_EN
    repeat (50020) @(negedge CLOCK_50);
    fe_exp++;
    check_eq("fe_watchdog", fe_cycles, fe_exp);
`else
    repeat (300) @(negedge CLOCK_50);
    check_eq("fe_no_watchdog", fe_cycles, fe_exp);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    mx = 80;
    my = 60;
    @(negedge CLOCK_50);
    check_eq("rst2_x", int'(mouse_x), 80);
`endif
    send_packet(8'h0A, 8'h03, 8'hFE);

    check_eq("fe_total", fe_cycles, fe_exp);
    check_eq("pv_total", pv_count, pv_exp);
    check_eq("strobe_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
